// File: rtl/axis_stream_fork.sv
// ---------------------------------------------------------------------------
// axis_stream_fork
//
// One-in, two-out AXI-Stream broadcast. Every accepted input beat is written
// into two independent DEPTH-entry FIFOs at once, so the two consumers can
// stall independently of each other. The input only accepts when both FIFOs
// have room. When one consumer falls DEPTH beats behind the other, it throttles
// the producer.
//
// Parameters
//   DATA_WIDTH : beat width in bits (>= 1)
//   DEPTH      : entries per output FIFO (power of two, >= 2)
//   CNT_W      : derived occupancy width, $clog2(DEPTH+1)
//
// Ports
//   ap_clk, ap_rst_n          : clock; async-assert active-low reset
//   s_axis_input0_*           : input stream (tdata/tvalid in, tready out)
//   m_axis_output0_*          : copy 0 (tdata/tvalid out, tready in)
//   m_axis_output1_*          : copy 1 (tdata/tvalid out, tready in)
//   occ0, occ1                : current occupancy of FIFO 0 / FIFO 1
// ---------------------------------------------------------------------------
module axis_stream_fork #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 2,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,

  input  logic [DATA_WIDTH-1:0] s_axis_input0_tdata,
  input  logic                  s_axis_input0_tvalid,
  output logic                  s_axis_input0_tready,

  output logic [DATA_WIDTH-1:0] m_axis_output0_tdata,
  output logic                  m_axis_output0_tvalid,
  input  logic                  m_axis_output0_tready,

  output logic [DATA_WIDTH-1:0] m_axis_output1_tdata,
  output logic                  m_axis_output1_tvalid,
  input  logic                  m_axis_output1_tready,

  output logic [CNT_W-1:0]      occ0,
  output logic [CNT_W-1:0]      occ1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NOUT  = 2;

  // Storage and pointers. The write pointer is shared because both FIFOs
  // always receive the same write; read pointers and counts are per output.
  logic [DATA_WIDTH-1:0] mem_q [NOUT][DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [NOUT][DEPTH];
  logic [PTR_W-1:0]      wp_q, wp_d;
  logic [PTR_W-1:0]      rp_q  [NOUT];
  logic [PTR_W-1:0]      rp_d  [NOUT];
  logic [CNT_W-1:0]      cnt_q [NOUT];
  logic [CNT_W-1:0]      cnt_d [NOUT];

  logic [NOUT-1:0]       m_tready;
  logic [NOUT-1:0]       m_tvalid;
  logic [NOUT-1:0]       pop;
  logic                  s_ready;
  logic                  push;

  assign m_tready = {m_axis_output1_tready, m_axis_output0_tready};

  // Handshake decode. Input ready looks only at registered counts, so a
  // slot freed by a pop this cycle is usable next cycle; this keeps any
  // consumer tready off the combinational path to the producer.
  always_comb begin
    s_ready = ap_rst_n
              && (cnt_q[0] < CNT_W'(DEPTH))
              && (cnt_q[1] < CNT_W'(DEPTH));
    push    = s_axis_input0_tvalid && s_ready;
    for (int k = 0; k < NOUT; k++) begin
      m_tvalid[k] = (cnt_q[k] != '0);
      pop[k]      = m_tvalid[k] && m_tready[k];
    end
  end

  // Next-state computation.
  // NOTE: every *_d is given its hold value before any conditional update, so
  // no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    wp_d = wp_q;
    if (push) begin
      wp_d = wp_q + PTR_W'(1);  // DEPTH is a power of two: wraps for free
    end

    for (int k = 0; k < NOUT; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[k][i] = mem_q[k][i];
      end
      rp_d[k]  = rp_q[k];
      cnt_d[k] = cnt_q[k];

      if (push) begin
        mem_d[k][wp_q] = s_axis_input0_tdata;
      end
      if (pop[k]) begin
        rp_d[k] = rp_q[k] + PTR_W'(1);
      end

      // Full/empty come from the count, so pointer equality is never
      // ambiguous after wrap.
      case ({push, pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CNT_W'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CNT_W'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  // State registers.
  // NOTE: non-blocking assignments here so every flop samples the value
  // from before the edge, independent of statement order.
  // NOTE: the storage array is reset too, so both tdata outputs read 0 out
  // of reset rather than stale or X contents; at this depth the cost is a
  // handful of reset pins.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wp_q <= '0;
      for (int k = 0; k < NOUT; k++) begin
        rp_q[k]  <= '0;
        cnt_q[k] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[k][i] <= '0;
        end
      end
    end else begin
      wp_q <= wp_d;
      for (int k = 0; k < NOUT; k++) begin
        rp_q[k]  <= rp_d[k];
        cnt_q[k] <= cnt_d[k];
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[k][i] <= mem_d[k][i];
        end
      end
    end
  end

  // Outputs: head of each FIFO presented straight from storage. The head
  // cannot change until it is popped, which keeps tvalid/tdata stable under
  // backpressure.
  assign s_axis_input0_tready  = s_ready;
  assign m_axis_output0_tvalid = m_tvalid[0];
  assign m_axis_output1_tvalid = m_tvalid[1];
  assign m_axis_output0_tdata  = mem_q[0][rp_q[0]];
  assign m_axis_output1_tdata  = mem_q[1][rp_q[1]];
  assign occ0                  = cnt_q[0];
  assign occ1                  = cnt_q[1];

endmodule
